// File: rtl/npc_fetch_unit.sv
// npc_fetch_unit: F-stage PC register and next-PC selection.
//
// Takes the D-stage branch-compare result and next-PC select and updates the fetch PC.
// The instruction already in F when a branch resolves in D is the MIPS delay slot and is
// never flushed; the new PC takes effect one cycle after the D-stage resolve.
//
// Optional feature macro: BR_STAT_EN. When defined, this block adds the branch statistic
// counters br_total and br_taken_cnt.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   stall        in   hazard freeze; 1 = hold pc_f
//   npc_op       in   00 seq, 01 cond branch, 10 j/jal, 11 jr/jalr
//   cmp_out      in   branch condition (taken = 1), used when npc_op = 01
//   pc_d         in   PC of the instruction in D
//   imm16        in   branch offset in words
//   index26      in   jump index
//   jr_target    in   forwarded rs value for jr/jalr
//   pc_f         out  registered fetch PC
//   pc_f_plus4   out  pc_f + 4
//   link_pc      out  pc_d + 8, the link write-back value
//   redirect     out  next PC is not pc_f + 4
//   jr_misalign  out  sticky flag: a register jump had a non-word-aligned target
//   br_total     out  (BR_STAT_EN) number of resolved conditional branches
//   br_taken_cnt out  (BR_STAT_EN) number of taken conditional branches
module npc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       npc_op,
  input  logic             cmp_out,
  input  logic [31:0]      pc_d,
  input  logic [15:0]      imm16,
  input  logic [25:0]      index26,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc_f,
  output logic [31:0]      pc_f_plus4,
  output logic [31:0]      link_pc,
  output logic             redirect,
  output logic             jr_misalign
`ifdef BR_STAT_EN
  ,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken_cnt
`endif
);

  logic [31:0] pc_f_q, pc_f_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_target;
  logic [31:0] npc;

  always_comb begin
    pc_f_plus4 = pc_f_q + 32'd4;
    pc_d_plus4 = pc_d + 32'd4;
    link_pc    = pc_d + 32'd8;
    // Word offset: sign-extend and scale by 4 in one concatenation.
    br_target  = pc_d_plus4 + {{14{imm16[15]}}, imm16, 2'b00};

    npc      = pc_f_plus4;
    redirect = 1'b0;
    unique case (npc_op)
      2'b00: begin
        npc      = pc_f_plus4;
        redirect = 1'b0;
      end
      2'b01: begin
        npc      = cmp_out ? br_target : pc_f_plus4;
        redirect = cmp_out;
      end
      2'b10: begin
        npc      = {pc_d_plus4[31:28], index26, 2'b00};
        redirect = 1'b1;
      end
      2'b11: begin
        // Misaligned targets are still followed, rounded down to the word.
        npc      = {jr_target[31:2], 2'b00};
        redirect = 1'b1;
      end
      default: begin
        npc      = pc_f_plus4;
        redirect = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_f_d     = pc_f_q;
    misalign_d = misalign_q;
    if (!stall) begin
      pc_f_d = npc;
      if (npc_op == 2'b11 && jr_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f_q     <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_f_q     <= pc_f_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_f        = pc_f_q;
  assign jr_misalign = misalign_q;

`ifdef BR_STAT_EN
  logic [CNT_W-1:0] br_total_q, br_total_d;
  logic [CNT_W-1:0] br_taken_q, br_taken_d;

  // Only non-stall edges count, so a branch held in D is counted once.
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (!stall && npc_op == 2'b01) begin
      br_total_d = br_total_q + 1'b1;
      if (cmp_out) begin
        br_taken_d = br_taken_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_total     = br_total_q;
  assign br_taken_cnt = br_taken_q;
`else
  // Counter width only matters when the statistics are built in.
  if (CNT_W == 0) begin : g_cnt_w_zero
  end
`endif

endmodule
